input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DET_DEBOUNCE_MS, default 3, SHALL set the consecutive 1 ms ticks a detector mismatch must persist before the clean output follows; legal range 1..255.
REQ-002 Parameter BTN_DEBOUNCE_MS, default 10, SHALL set the same for button channels; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 tick_1ms  input  1  SHALL be a one-clk-wide enable pulse, high once per millisecond, synchronous to clk.
REQ-006 semi_auto_enable  input  1  SHALL gate press-pulse generation.
REQ-007 det_raw  input  4  SHALL carry the asynchronous detector lines, bit order {front, back, left, right}.
REQ-008 btn_raw  input  4  SHALL carry the asynchronous push-button lines, same bit order.
REQ-009 det_clean  output  4  SHALL carry the debounced detector levels feeding semi_auto front/back/left/right_detector.
REQ-010 btn_clean  output  4  SHALL carry the debounced button levels feeding semi_auto bu_front/back/left/right.
REQ-011 btn_press  output  4  SHALL carry single-cycle press pulses, one-hot or zero.

Function
REQ-012 Each of the 8 raw lines SHALL pass a 2-flop synchronizer; sync value lags raw by 2 clk.
REQ-013 Each channel SHALL have an 8-bit counter; when sync value equals clean value the counter SHALL clear to 0 on the next clk.
REQ-014 While sync differs from clean, the counter SHALL increment on each clk where tick_1ms=1, and hold otherwise.
REQ-015 On the tick where the counter would reach the channel's parameter N, clean SHALL take the sync value and the counter SHALL clear, both at that clk edge.
REQ-016 Any single-clk return of sync to clean SHALL restart the count from 0 (mismatch must be continuous across N ticks).
REQ-017 Worst-case latency raw-to-clean SHALL be 2 clk + N ticks + 1 clk; minimum 2 clk + (N-1) tick periods + 1 clk.
REQ-018 Each button channel SHALL have an armed flag, cleared by reset, set when btn_clean for that channel is 0 on a tick edge.
REQ-019 btn_press[i] SHALL assert for exactly one clk in the cycle after btn_clean[i] rises, only if armed[i]=1 and semi_auto_enable=1 at that rising edge.
REQ-020 Simultaneous rising edges on several buttons SHALL produce a pulse only on the highest-priority one (front > back > left > right); the others are dropped, not queued.
REQ-021 Edges occurring while semi_auto_enable=0 SHALL be lost; btn_clean and det_clean SHALL keep updating regardless of enable.
REQ-022 Falling edges of btn_clean SHALL never produce a pulse.
REQ-023 Counters SHALL saturate at N and never wrap.

Reset
REQ-024 rst=0 SHALL asynchronously clear synchronizers, counters, armed flags, det_clean, btn_clean, btn_press to 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release counting SHALL restart from 0.
REQ-026 A button held high through reset release SHALL reach btn_clean=1 after N ticks but SHALL NOT produce btn_press until released (debounced low) and pressed again.

Verification
REQ-027 Bench with tick_1ms every 10 clk, defaults. Reset, det_raw=4'b0110 held -> det_clean=4'b0110 after 3 ticks (+3 clk), btn_press stays 0.
REQ-028 det_raw bit left toggles 1 clk low every 2 ticks for 20 ticks -> det_clean[1] stays 1, no change.
REQ-029 enable=1, btn_raw=4'b1000 held 12 ticks then 0 -> btn_clean[3] rises after 10 ticks, btn_press=4'b1000 for exactly 1 clk, no pulse on release.
REQ-030 btn_raw 4'b0000 -> 4'b0011 same cycle, armed -> single btn_press=4'b0010; btn_clean=4'b0011.
REQ-031 enable=0 during press of right button -> btn_clean[0]=1, btn_press=0; enable raised later -> still no pulse.
REQ-032 btn_raw=4'b0100 held across reset release -> btn_clean=4'b0100 after 10 ticks, no pulse; release 12 ticks, press 12 ticks -> btn_press=4'b0100 once; rst pulse at tick 5 of a debounce -> count restarts, clean after 10 further ticks.

Source files
------------

// File: rtl/input_conditioner.sv
// Input conditioner: synchronizes and debounces four detector lines and four
// push-button lines, and turns debounced button presses into single-cycle
// pulses gated by semi_auto_enable. Bit order is {front, back, left, right}.
module input_conditioner #(
    parameter int unsigned DET_DEBOUNCE_MS = 3,
    parameter int unsigned BTN_DEBOUNCE_MS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       semi_auto_enable,
    input  logic [3:0] det_raw,
    input  logic [3:0] btn_raw,
    output logic [3:0] det_clean,
    output logic [3:0] btn_clean,
    output logic [3:0] btn_press
);

    localparam int unsigned NCH  = 4;
    localparam int unsigned NALL = 2 * NCH;
    localparam int unsigned CW   = 8;

    localparam logic [CW-1:0] DET_N = CW'(DET_DEBOUNCE_MS);
    localparam logic [CW-1:0] BTN_N = CW'(BTN_DEBOUNCE_MS);

    // Channels 0..3 are detectors, 4..7 are buttons.
    localparam logic [NALL-1:0][CW-1:0] LIMITS = {{NCH{BTN_N}}, {NCH{DET_N}}};

    logic [NALL-1:0]         sync1_q, sync1_d;
    logic [NALL-1:0]         sync2_q, sync2_d;
    logic [NALL-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NALL-1:0]         clean_q, clean_d;
    logic [NCH-1:0]          armed_q, armed_d;
    logic [NCH-1:0]          press_q, press_d;
    logic [1:0]              settle_q, settle_d;

    logic [NCH-1:0]          btn_sync_c;
    logic [NCH-1:0]          btn_clean_now_c;
    logic [NCH-1:0]          btn_clean_next_c;
    logic [NCH-1:0]          press_cand_c;

    assign btn_sync_c       = sync2_q[NALL-1:NCH];
    assign btn_clean_now_c  = clean_q[NALL-1:NCH];
    assign btn_clean_next_c = clean_d[NALL-1:NCH];

    // Two-flop synchronizers; settle marks when the synchronizer pipeline
    // holds real post-reset samples rather than reset zeros.
    always_comb begin
        sync1_d  = {btn_raw, det_raw};
        sync2_d  = sync1_q;
        settle_d = {settle_q[0], 1'b1};
    end

    // Debounce: count ticks of continuous mismatch, adopt sync value at N.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(NALL); i++) begin
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_1ms) begin
                if (cnt_q[i] >= LIMITS[i] - CW'(1)) begin
                    clean_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Arming: a button is armed only after it has been seen stably low on a
    // tick with a settled synchronizer, so a button held through reset
    // cannot fire until it is released and pressed again.
    always_comb begin
        armed_d = armed_q;
        for (int i = 0; i < int'(NCH); i++) begin
            if (btn_clean_now_c[i]) begin
                armed_d[i] = 1'b0;
            end else if (tick_1ms && settle_q[1] && !btn_sync_c[i]) begin
                armed_d[i] = 1'b1;
            end
        end
    end

    // Press pulse on a debounced rising edge; front > back > left > right.
    always_comb begin
        press_cand_c = btn_clean_next_c & ~btn_clean_now_c & armed_q
                       & {NCH{semi_auto_enable}};
        press_d      = '0;
        if (press_cand_c[3]) begin
            press_d = 4'b1000;
        end else if (press_cand_c[2]) begin
            press_d = 4'b0100;
        end else if (press_cand_c[1]) begin
            press_d = 4'b0010;
        end else if (press_cand_c[0]) begin
            press_d = 4'b0001;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            clean_q  <= '0;
            armed_q  <= '0;
            press_q  <= '0;
            settle_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
            settle_q <= settle_d;
        end
    end

    assign det_clean = clean_q[NCH-1:0];
    assign btn_clean = clean_q[NALL-1:NCH];
    assign btn_press = press_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: tick every 10 clk, default debounce.
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic       tick_1ms;
    logic       semi_auto_enable;
    logic [3:0] det_raw;
    logic [3:0] btn_raw;
    logic [3:0] det_clean;
    logic [3:0] btn_clean;
    logic [3:0] btn_press;

    int n_vec;
    int n_err;
    int press_cnt [4];
    int press_base [4];
    int onehot_err;
    int tick_cnt;

    typedef struct {
        logic [3:0] det;
        logic [3:0] btn;
        logic       en;
        int         ticks;
        logic [3:0] exp_det;
        logic [3:0] exp_btn;
        logic [3:0] exp_mask;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [16];

    input_conditioner dut (
        .clk              (clk),
        .rst              (rst),
        .tick_1ms         (tick_1ms),
        .semi_auto_enable (semi_auto_enable),
        .det_raw          (det_raw),
        .btn_raw          (btn_raw),
        .det_clean        (det_clean),
        .btn_clean        (btn_clean),
        .btn_press        (btn_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk tick every 10 clk, changed on the falling edge.
    initial begin
        tick_1ms = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            tick_cnt = (tick_cnt == 9) ? 0 : tick_cnt + 1;
            tick_1ms = (tick_cnt == 9);
        end
    end

    // Press monitor: per-bit pulse counts and one-hot violations.
    initial begin
        for (int i = 0; i < 4; i++) press_cnt[i] = 0;
        onehot_err = 0;
        forever begin
            @(negedge clk);
            if (btn_press != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (btn_press[i]) press_cnt[i] = press_cnt[i] + 1;
                if ($countones(btn_press) != 1) onehot_err = onehot_err + 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            @(posedge clk);
            while (!tick_1ms && guard < 20) begin
                @(posedge clk);
                guard = guard + 1;
            end
            if (guard >= 20) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL tick_timeout: got no tick expected tick within 20 clk");
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) press_base[i] = press_cnt[i];
    endtask

    task automatic get_press(output logic [3:0] mask, output int cnt);
        mask = 4'b0000;
        cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            if (press_cnt[i] != press_base[i]) mask[i] = 1'b1;
            cnt = cnt + press_cnt[i] - press_base[i];
        end
    endtask

    initial begin
        logic [3:0] mask;
        int         cnt;
        n_vec = 0;
        n_err = 0;

        //          det      btn      en    t   exp_det  exp_btn  mask     cnt
        vecs[0]  = '{4'b0110, 4'b0000, 1'b1, 2,  4'b0000, 4'b0000, 4'b0000, 0};
        vecs[1]  = '{4'b0110, 4'b0000, 1'b1, 1,  4'b0110, 4'b0000, 4'b0000, 0};
        vecs[2]  = '{4'b0110, 4'b1000, 1'b1, 9,  4'b0110, 4'b0000, 4'b0000, 0};
        vecs[3]  = '{4'b0110, 4'b1000, 1'b1, 1,  4'b0110, 4'b1000, 4'b1000, 1};
        vecs[4]  = '{4'b0110, 4'b1000, 1'b1, 2,  4'b0110, 4'b1000, 4'b0000, 0};
        vecs[5]  = '{4'b0110, 4'b0000, 1'b1, 10, 4'b0110, 4'b0000, 4'b0000, 0};
        vecs[6]  = '{4'b0110, 4'b0000, 1'b1, 1,  4'b0110, 4'b0000, 4'b0000, 0};
        vecs[7]  = '{4'b0110, 4'b0011, 1'b1, 10, 4'b0110, 4'b0011, 4'b0010, 1};
        vecs[8]  = '{4'b0110, 4'b0000, 1'b1, 10, 4'b0110, 4'b0000, 4'b0000, 0};
        vecs[9]  = '{4'b0110, 4'b0000, 1'b1, 1,  4'b0110, 4'b0000, 4'b0000, 0};
        vecs[10] = '{4'b0110, 4'b0001, 1'b0, 10, 4'b0110, 4'b0001, 4'b0000, 0};
        vecs[11] = '{4'b0110, 4'b0001, 1'b1, 5,  4'b0110, 4'b0001, 4'b0000, 0};
        vecs[12] = '{4'b0110, 4'b0000, 1'b1, 11, 4'b0110, 4'b0000, 4'b0000, 0};
        vecs[13] = '{4'b0000, 4'b0000, 1'b1, 2,  4'b0110, 4'b0000, 4'b0000, 0};
        vecs[14] = '{4'b0000, 4'b0000, 1'b1, 1,  4'b0000, 4'b0000, 4'b0000, 0};
        vecs[15] = '{4'b0110, 4'b0000, 1'b1, 3,  4'b0110, 4'b0000, 4'b0000, 0};

        rst              = 1'b0;
        semi_auto_enable = 1'b0;
        det_raw          = 4'b0000;
        btn_raw          = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_det_clean", 32'(det_clean), 32'h0);
        check("reset_btn_clean", 32'(btn_clean), 32'h0);
        check("reset_btn_press", 32'(btn_press), 32'h0);
        rst              = 1'b1;
        semi_auto_enable = 1'b1;
        wait_ticks(2);

        for (int v = 0; v < 16; v++) begin
            det_raw          = vecs[v].det;
            btn_raw          = vecs[v].btn;
            semi_auto_enable = vecs[v].en;
            snap();
            wait_ticks(vecs[v].ticks);
            get_press(mask, cnt);
            check($sformatf("vec%0d_det_clean", v), 32'(det_clean), 32'(vecs[v].exp_det));
            check($sformatf("vec%0d_btn_clean", v), 32'(btn_clean), 32'(vecs[v].exp_btn));
            check($sformatf("vec%0d_press_mask", v), 32'(mask), 32'(vecs[v].exp_mask));
            check($sformatf("vec%0d_press_count", v), 32'(cnt), 32'(vecs[v].exp_cnt));
        end

        // Left detector glitches low for one clk landing on a tick edge.
        for (int g = 0; g < 10; g++) begin
            wait_ticks(1);
            repeat (7) @(negedge clk);
            det_raw[1] = 1'b0;
            @(negedge clk);
            det_raw[1] = 1'b1;
            wait_ticks(1);
            check($sformatf("glitch%0d_det_clean", g), 32'(det_clean), 32'h6);
        end

        // Button held high through reset release.
        snap();
        btn_raw = 4'b0100;
        rst     = 1'b0;
        @(negedge clk);
        check("held_rst_btn_clean", 32'(btn_clean), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(9);
        check("held_9_btn_clean", 32'(btn_clean), 32'h0);
        wait_ticks(1);
        check("held_10_btn_clean", 32'(btn_clean), 32'h4);
        get_press(mask, cnt);
        check("held_press_count", 32'(cnt), 32'h0);
        btn_raw = 4'b0000;
        wait_ticks(12);
        check("held_release_btn_clean", 32'(btn_clean), 32'h0);
        snap();
        btn_raw = 4'b0100;
        wait_ticks(12);
        get_press(mask, cnt);
        check("repress_btn_clean", 32'(btn_clean), 32'h4);
        check("repress_press_mask", 32'(mask), 32'h4);
        check("repress_press_count", 32'(cnt), 32'h1);
        btn_raw = 4'b0000;
        wait_ticks(12);
        check("repress_release_btn_clean", 32'(btn_clean), 32'h0);

        // Reset after 5 ticks of a debounce discards the partial count.
        snap();
        btn_raw = 4'b0001;
        wait_ticks(5);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(9);
        check("midrst_9_btn_clean", 32'(btn_clean), 32'h0);
        wait_ticks(1);
        check("midrst_10_btn_clean", 32'(btn_clean), 32'h1);
        get_press(mask, cnt);
        check("midrst_press_count", 32'(cnt), 32'h0);

        check("press_onehot_violations", 32'(onehot_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
